// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch sequencer state type.
package cpu_pkg;

    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned IMM_FLAG_BIT = 7;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        ADDR,
        OPCODE,
        IMM,
        VALID
    } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: synchronous reset, load has priority over increment, wraps at the top.
module pc_counter #(
    parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_loadValue,
    input  logic              i_increment,
    output logic [ADDR_W-1:0] o_pc
);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_pc <= RESET_PC;
        end else if (i_load) begin
            o_pc <= i_loadValue;
        end else if (i_increment) begin
            o_pc <= o_pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads opcode/immediate byte pairs and presents them over valid/ready.
// Optional build macro FETCH_SKIP_IMM_EN skips the immediate read for opcodes without the immediate flag.
module fetch_unit #(
    parameter int unsigned       ADDR_W       = cpu_pkg::ADDR_W,
    parameter int unsigned       DATA_W       = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC     = cpu_pkg::RESET_PC,
    parameter int unsigned       IMM_FLAG_BIT = cpu_pkg::IMM_FLAG_BIT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_busData,
    input  logic              i_memBusy,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jumpTarget,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_addressEn,
    output logic              o_readDataSelect,
    output logic              o_immediateSelect,
    output logic              o_outEnable,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_opcode,
    output logic [DATA_W-1:0] o_immediate,
    output logic [ADDR_W-1:0] o_pc
);

    import cpu_pkg::*;

    if (IMM_FLAG_BIT >= DATA_W) begin : g_badImmFlag
        $error("fetch_unit: IMM_FLAG_BIT must index a bit of the opcode byte");
    end

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              pcIncrement;
    logic              hasImm;
    logic              busFree;

`ifdef FETCH_SKIP_IMM_EN
    assign hasImm = i_busData[IMM_FLAG_BIT];
`else
    assign hasImm = 1'b1;
`endif

    assign busFree = !i_reset && !i_memBusy;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pcCounter (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (i_jump),
        .i_loadValue (i_jumpTarget),
        .i_increment (pcIncrement),
        .o_pc        (pc)
    );

    // The pc advances on the last byte read of an instruction; a jump or bus loss cancels it.
    always_comb begin
        pcIncrement = 1'b0;
        if (!i_jump && !i_memBusy) begin
            if (state == IMM) begin
                pcIncrement = 1'b1;
            end else if (state == OPCODE && !hasImm) begin
                pcIncrement = 1'b1;
            end
        end
    end

    // Memory controls follow the state directly so a data access can take the bus the same cycle.
    always_comb begin
        o_address         = i_reset ? '0 : pc;
        o_addressEn       = busFree && (state == ADDR);
        o_outEnable       = busFree && (state == OPCODE || state == IMM);
        o_readDataSelect  = busFree && (state == OPCODE || state == IMM);
        o_immediateSelect = busFree && (state == IMM);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ADDR;
            o_valid     <= 1'b0;
            o_opcode    <= '0;
            o_immediate <= '0;
            o_pc        <= '0;
        end else if (i_jump) begin
            state   <= ADDR;
            o_valid <= 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (!i_memBusy) begin
                        state <= OPCODE;
                    end
                end
                OPCODE: begin
                    if (i_memBusy) begin
                        state <= ADDR;
                    end else begin
                        o_opcode <= i_busData;
                        o_pc     <= pc;
                        if (hasImm) begin
                            state <= IMM;
                        end else begin
                            o_immediate <= '0;
                            o_valid     <= 1'b1;
                            state       <= VALID;
                        end
                    end
                end
                IMM: begin
                    if (i_memBusy) begin
                        state <= ADDR;
                    end else begin
                        o_immediate <= i_busData;
                        o_valid     <= 1'b1;
                        state       <= VALID;
                    end
                end
                VALID: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= ADDR;
                    end
                end
                default: state <= ADDR;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then random ready/busy/jump traffic against an instruction-stream model.
module tb_fetch_unit;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_busData;
    logic       i_memBusy;
    logic       i_jump;
    logic [7:0] i_jumpTarget;
    logic       i_ready;
    logic [7:0] o_address;
    logic       o_addressEn;
    logic       o_readDataSelect;
    logic       o_immediateSelect;
    logic       o_outEnable;
    logic       o_valid;
    logic [7:0] o_opcode;
    logic [7:0] o_immediate;
    logic [7:0] o_pc;

    always #5 i_clk = ~i_clk;

    fetch_unit dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_busData         (i_busData),
        .i_memBusy         (i_memBusy),
        .i_jump            (i_jump),
        .i_jumpTarget      (i_jumpTarget),
        .i_ready           (i_ready),
        .o_address         (o_address),
        .o_addressEn       (o_addressEn),
        .o_readDataSelect  (o_readDataSelect),
        .o_immediateSelect (o_immediateSelect),
        .o_outEnable       (o_outEnable),
        .o_valid           (o_valid),
        .o_opcode          (o_opcode),
        .o_immediate       (o_immediate),
        .o_pc              (o_pc)
    );

    // Memory model: address register loaded on enable, clobbered by data accesses.
    logic [7:0] rom0 [256];
    logic [7:0] rom1 [256];
    logic [7:0] memAddr;

    always @(posedge i_clk) begin
        if (o_addressEn) memAddr <= o_address;
        else if (i_memBusy) memAddr <= 8'($urandom);
    end

    assign i_busData = (o_outEnable && o_readDataSelect)
                     ? (o_immediateSelect ? rom1[memAddr] : rom0[memAddr])
                     : ~memAddr;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expImm(input logic [7:0] pc);
`ifdef FETCH_SKIP_IMM_EN
        return rom0[pc][7] ? rom1[pc] : 8'h00;
`else
        return rom1[pc];
`endif
    endfunction

    // Clock edges from the address cycle until the instruction is presented.
    function automatic int expLat(input logic [7:0] pc);
`ifdef FETCH_SKIP_IMM_EN
        return rom0[pc][7] ? 3 : 2;
`else
        return 3;
`endif
    endfunction

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic waitValid(input int limit, output int n);
        n = 0;
        while (!o_valid && n < limit) begin
            step();
            n++;
        end
        check("valid_within_bound", 8'(o_valid), 8'd1);
    endtask

    int         n;
    logic [7:0] expPc;
    logic [7:0] holdOp, holdImm, holdPc;
    logic       prevHold;

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom0[i] = 8'($urandom);
            rom1[i] = 8'($urandom);
        end
        rom0[8'h00] = 8'h12;
        rom1[8'h00] = 8'h34;
        rom0[8'h01] = rom0[8'h01] | 8'h80;
        rom0[8'h50] = 8'h05;
        rom0[8'h51] = 8'h85;

        i_reset = 1'b1; i_memBusy = 1'b0; i_jump = 1'b0; i_jumpTarget = 8'h00; i_ready = 1'b1;
        step(); step();
        check("rst_valid", 8'(o_valid), 8'd0);
        check("rst_opcode", o_opcode, 8'h00);
        check("rst_imm", o_immediate, 8'h00);
        check("rst_pc", o_pc, 8'h00);
        check("rst_addren", 8'(o_addressEn), 8'd0);
        check("rst_oe", 8'(o_outEnable), 8'd0);
        check("rst_addr", o_address, 8'h00);

        // First fetch after reset.
        i_reset = 1'b0; #1;
        check("first_addren", 8'(o_addressEn), 8'd1);
        check("first_addr", o_address, 8'h00);
        waitValid(10, n);
        check("first_latency", 8'(n), 8'(expLat(8'h00)));
        check("first_opcode", o_opcode, 8'h12);
        check("first_imm", o_immediate, expImm(8'h00));
        check("first_pc", o_pc, 8'h00);
        step();
        check("next_addr", o_address, 8'h01);
        check("next_addren", 8'(o_addressEn), 8'd1);

        // Fetch at the top of memory and wrap.
        i_jump = 1'b1; i_jumpTarget = 8'hFF;
        step();
        i_jump = 1'b0; #1;
        check("jump_ff_addr", o_address, 8'hFF);
        waitValid(10, n);
        check("ff_opcode", o_opcode, rom0[8'hFF]);
        check("ff_pc", o_pc, 8'hFF);
        step();
        check("wrap_addr", o_address, 8'h00);

        // Bus taken during the opcode read forces a refetch.
        step();
        i_memBusy = 1'b1; #1;
        check("busy_oe", 8'(o_outEnable), 8'd0);
        check("busy_rds", 8'(o_readDataSelect), 8'd0);
        check("busy_addren", 8'(o_addressEn), 8'd0);
        step();
        i_memBusy = 1'b0; #1;
        check("refetch_addren", 8'(o_addressEn), 8'd1);
        check("refetch_addr", o_address, 8'h00);
        waitValid(10, n);
        check("refetch_latency", 8'(n), 8'(expLat(8'h00)));
        check("refetch_opcode", o_opcode, 8'h12);
        check("refetch_imm", o_immediate, expImm(8'h00));

        // Jump during the immediate read discards the instruction.
        step(); step(); step();
        check("in_imm_state", 8'(o_immediateSelect), 8'd1);
        i_jump = 1'b1; i_jumpTarget = 8'h40;
        step();
        i_jump = 1'b0; #1;
        check("jump_no_valid", 8'(o_valid), 8'd0);
        check("jump_addr", o_address, 8'h40);
        waitValid(10, n);
        check("jump_pc", o_pc, 8'h40);
        check("jump_opcode", o_opcode, rom0[8'h40]);

        // Stall in VALID.
        step();
        i_ready = 1'b0;
        waitValid(10, n);
        holdOp = o_opcode; holdImm = o_immediate; holdPc = o_pc;
        check("hold_pc_value", holdPc, 8'h41);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", 8'(o_valid), 8'd1);
            check("hold_opcode", o_opcode, holdOp);
            check("hold_imm", o_immediate, holdImm);
            check("hold_nobus", 8'({o_addressEn, o_outEnable}), 8'd0);
        end
        i_ready = 1'b1;
        step();
        check("release_addren", 8'(o_addressEn), 8'd1);
        check("release_valid", 8'(o_valid), 8'd0);
        check("release_addr", o_address, 8'h42);

        // Opcodes with and without the immediate flag.
        i_jump = 1'b1; i_jumpTarget = 8'h50;
        step();
        i_jump = 1'b0;
        waitValid(10, n);
        check("op05_latency", 8'(n), 8'(expLat(8'h50)));
        check("op05_imm", o_immediate, expImm(8'h50));
        step();
        waitValid(10, n);
        check("op85_latency", 8'(n), 8'(expLat(8'h51)));
        check("op85_imm", o_immediate, rom1[8'h51]);

        // Random traffic against the instruction-stream model.
        expPc = 8'($urandom);
        i_jump = 1'b1; i_jumpTarget = expPc;
        step();
        i_jump = 1'b0;
        prevHold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            i_ready      = ($urandom % 10) < 7;
            i_memBusy    = ($urandom % 100) < 15;
            i_jump       = ($urandom % 100) < 4;
            i_jumpTarget = 8'($urandom);
            #1;
            if (prevHold) begin
                check("rnd_hold_valid", 8'(o_valid), 8'd1);
                check("rnd_hold_opcode", o_opcode, holdOp);
                check("rnd_hold_imm", o_immediate, holdImm);
                check("rnd_hold_pc", o_pc, holdPc);
            end
            if (o_valid) begin
                check("rnd_valid_nobus", 8'({o_addressEn, o_outEnable}), 8'd0);
            end
            if (o_valid && i_ready) begin
                check("rnd_pc", o_pc, expPc);
                check("rnd_opcode", o_opcode, rom0[expPc]);
                check("rnd_imm", o_immediate, expImm(expPc));
                expPc = expPc + 8'd1;
            end
            if (i_jump) expPc = i_jumpTarget;
            prevHold = o_valid && !i_ready && !i_jump;
            holdOp = o_opcode; holdImm = o_immediate; holdPc = o_pc;
            step();
        end

        // Reset in the middle of a fetch.
        i_jump = 1'b0; i_memBusy = 1'b0; i_ready = 1'b1;
        step(); step();
        i_reset = 1'b1;
        step();
        check("midrst_valid", 8'(o_valid), 8'd0);
        check("midrst_opcode", o_opcode, 8'h00);
        check("midrst_imm", o_immediate, 8'h00);
        check("midrst_pc", o_pc, 8'h00);
        check("midrst_addr", o_address, 8'h00);
        check("midrst_bus", 8'({o_addressEn, o_outEnable, o_readDataSelect, o_immediateSelect}), 8'd0);
        i_reset = 1'b0; #1;
        check("midrst_addren", 8'(o_addressEn), 8'd1);
        waitValid(10, n);
        check("midrst_refetch_opcode", o_opcode, 8'h12);
        check("midrst_refetch_pc", o_pc, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
